// File: rtl/sar_adc_seq.sv
// SAR conversion sequencer for the analog ADC macro: power/bias/offset-cancel control plus binary search on ADCMP.
// Latency: ADEND rises 1+OFC_CYC+2*RES cycles after the edge that samples ADSTART (4 passes when averaging).
// Backpressure: none; ADSTART is ignored while busy, remembered during warm-up. Optional build macro: SAR_ADC_AVG_EN.
module sar_adc_seq #(
    parameter int RES     = 10,
    parameter int WARMUP  = 16,
    parameter int OFC_CYC = 4
) (
    input  logic           CLK,
    input  logic           RESETB,
    input  logic           ADCE,
    input  logic           ADSTART,
    input  logic           ADCMP,
    output logic           ADBIONB,
    output logic           ADPDB,
    output logic           ADCPON,
    output logic           ADOFC,
    output logic [RES-1:0] ADTRIAL,
    output logic [RES-1:0] ADCR,
    output logic           ADBUSY,
    output logic           ADEND
);

    localparam int IW = $clog2(RES);
    localparam logic [RES-1:0] MSB_CODE  = {1'b1, {(RES-1){1'b0}}};
    localparam logic [7:0]     WARM_LOAD = 8'(WARMUP - 1);
    localparam logic [7:0]     OFC_LOAD  = 8'(OFC_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARM,
        S_READY,
        S_OFFC,
        S_CONV,
        S_DONE
    } state_t;

    state_t          state;
    logic [7:0]      cnt;        // shared down-counter for warm-up and offset cancel
    logic [IW-1:0]   bit_idx;    // bit currently under trial
    logic            phase_b;    // 0 = settle cycle, 1 = compare cycle
    logic            pending;    // start request seen during warm-up
    logic [RES-1:0]  bit_code;   // trial code with the current bit resolved
    logic [RES-1:0]  trial_nxt;  // resolved code plus the next lower trial bit
`ifdef SAR_ADC_AVG_EN
    logic [RES+1:0]  acc;        // running sum of the four pass results
    logic [RES+1:0]  acc_sum;
    logic [1:0]      pass;
`else
    logic [RES-1:0]  code;       // final code of the finished pass
`endif

    // Resolve the bit under trial from the comparator and prepare the next trial code.
    always_comb begin
        bit_code = ADTRIAL;
        if (!ADCMP) begin
            bit_code[bit_idx] = 1'b0;
        end
        trial_nxt = bit_code;
        if (bit_idx != '0) begin
            trial_nxt[bit_idx - IW'(1)] = 1'b1;
        end
`ifdef SAR_ADC_AVG_EN
        acc_sum = acc + {2'b00, bit_code};
`endif
    end

    // Sequencer FSM; every macro control and status output is registered here.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            phase_b <= 1'b0;
            pending <= 1'b0;
            ADBIONB <= 1'b1;
            ADPDB   <= 1'b0;
            ADCPON  <= 1'b0;
            ADOFC   <= 1'b0;
            ADTRIAL <= '0;
            ADCR    <= '0;
            ADBUSY  <= 1'b0;
            ADEND   <= 1'b0;
`ifdef SAR_ADC_AVG_EN
            acc     <= '0;
            pass    <= '0;
`else
            code    <= '0;
`endif
        end else begin
            ADEND <= 1'b0;
            if (!ADCE && state != S_IDLE) begin
                // Enable dropped: power the macro down and abandon any conversion without a result.
                state   <= S_IDLE;
                pending <= 1'b0;
                phase_b <= 1'b0;
                ADBIONB <= 1'b1;
                ADPDB   <= 1'b0;
                ADCPON  <= 1'b0;
                ADOFC   <= 1'b0;
                ADTRIAL <= '0;
                ADBUSY  <= 1'b0;
`ifdef SAR_ADC_AVG_EN
                acc     <= '0;
                pass    <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ADCE) begin
                            state   <= S_WARM;
                            ADBIONB <= 1'b0;
                            ADPDB   <= 1'b1;
                            cnt     <= WARM_LOAD;
                        end
                    end
                    S_WARM: begin
                        if (ADSTART) begin
                            pending <= 1'b1;
                        end
                        if (cnt == 8'd0) begin
                            state <= S_READY;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    S_READY: begin
                        if (ADSTART || pending) begin
                            state   <= S_OFFC;
                            pending <= 1'b0;
                            ADBUSY  <= 1'b1;
                            ADCPON  <= 1'b1;
                            ADOFC   <= 1'b1;
                            cnt     <= OFC_LOAD;
`ifdef SAR_ADC_AVG_EN
                            acc     <= '0;
                            pass    <= '0;
`endif
                        end
                    end
                    S_OFFC: begin
                        if (cnt == 8'd0) begin
                            state   <= S_CONV;
                            ADOFC   <= 1'b0;
                            bit_idx <= IW'(RES - 1);
                            phase_b <= 1'b0;
                            ADTRIAL <= MSB_CODE;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    S_CONV: begin
                        if (!phase_b) begin
                            phase_b <= 1'b1;
                        end else begin
                            phase_b <= 1'b0;
                            if (bit_idx != '0) begin
                                ADTRIAL <= trial_nxt;
                                bit_idx <= bit_idx - IW'(1);
                            end else begin
                                ADTRIAL <= '0;
`ifdef SAR_ADC_AVG_EN
                                acc <= acc_sum;
                                if (pass == 2'd3) begin
                                    state <= S_DONE;
                                end else begin
                                    // Next averaging pass starts with a fresh offset cancel.
                                    pass  <= pass + 2'd1;
                                    state <= S_OFFC;
                                    ADOFC <= 1'b1;
                                    cnt   <= OFC_LOAD;
                                end
`else
                                code  <= bit_code;
                                state <= S_DONE;
`endif
                            end
                        end
                    end
                    S_DONE: begin
`ifdef SAR_ADC_AVG_EN
                        ADCR <= acc[RES+1:2];
`else
                        ADCR <= code;
`endif
                        ADEND  <= 1'b1;
                        ADCPON <= 1'b0;
                        ADBUSY <= 1'b0;
                        state  <= S_READY;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
